// File: rtl/wb_reg_file.sv
// Write-back register file: two asynchronous read ports, a condition flag and a
// saturating commit counter. Define WB_REG_BYPASS_EN for same-cycle write-to-read bypass.
module wb_reg_file #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] datIn,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] dat_a,
  output logic [DATA_W-1:0] dat_b,
  input  logic              flag_wr_en,
  input  logic              flag_in,
  output logic              flag_out,
  output logic [7:0]        wr_count
);

  localparam logic [7:0] CNT_MAX = 8'hFF;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic              r_flag;
  logic [7:0]        r_wr_count;
  logic [DATA_W-1:0] w_stored_a;
  logic [DATA_W-1:0] w_stored_b;

  // NOTE: every entry is cleared on reset, so this array is built from flops, not a RAM.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wr_en) begin
      // NOTE: <= makes every process at this edge see the pre-edge register values.
      r_regs[wr_addr] <= datIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag <= 1'b0;
    end else if (flag_wr_en) begin
      r_flag <= flag_in;
    end
  end

  // Counts committed writes only; holds at CNT_MAX instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_count <= '0;
    end else if (wr_en && (r_wr_count != CNT_MAX)) begin
      r_wr_count <= r_wr_count + 8'd1;
    end
  end

  assign w_stored_a = r_regs[rd_addr_a];
  assign w_stored_b = r_regs[rd_addr_b];

`ifdef WB_REG_BYPASS_EN
  logic w_byp_a;
  logic w_byp_b;

  // Forward the incoming write data when a port reads the register being written.
  assign w_byp_a = wr_en && !reset && (rd_addr_a == wr_addr);
  assign w_byp_b = wr_en && !reset && (rd_addr_b == wr_addr);
  assign dat_a   = w_byp_a ? datIn : w_stored_a;
  assign dat_b   = w_byp_b ? datIn : w_stored_b;
`else
  assign dat_a   = w_stored_a;
  assign dat_b   = w_stored_b;
`endif

  assign flag_out = r_flag;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_reg_file.sv
// Randomized self-checking bench for wb_reg_file: array-based reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_wb_reg_file;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] datIn;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic [7:0] dat_a;
  logic [7:0] dat_b;
  logic       flag_wr_en;
  logic       flag_in;
  logic       flag_out;
  logic [7:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  wb_reg_file #(.DATA_W(8), .ADDR_W(3), .NUM_REGS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .datIn      (datIn),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .dat_a      (dat_a),
    .dat_b      (dat_b),
    .flag_wr_en (flag_wr_en),
    .flag_in    (flag_in),
    .flag_out   (flag_out),
    .wr_count   (wr_count)
  );

  always #5 clk = ~clk;

  // Reference model: plain array, flag bit and integer counter.
  logic [7:0] m_regs [8];
  logic       m_flag;
  int         m_count;
  bit         model_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_flag      = 1'b0;
      m_count     = 0;
      model_valid = 1'b1;
    end else begin
      if (wr_en) begin
        m_regs[wr_addr] = datIn;
        m_count         = (m_count + 1 > 255) ? 255 : m_count + 1;
      end
      if (flag_wr_en) m_flag = flag_in;
    end
  end

  function automatic logic [7:0] exp_read(input logic [2:0] addr);
`ifdef WB_REG_BYPASS_EN
    if (wr_en && !reset && (addr == wr_addr)) return datIn;
`endif
    return m_regs[addr];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("dat_a",    dat_a,    exp_read(rd_addr_a));
      check("dat_b",    dat_b,    exp_read(rd_addr_b));
      check("flag_out", flag_out, m_flag);
      check("wr_count", wr_count, m_count);
    end
  end

  task automatic drive(input logic rst, input logic we, input logic [2:0] wa,
                       input logic [7:0] d, input logic [2:0] ra, input logic [2:0] rb,
                       input logic fwe, input logic fin);
    reset = rst; wr_en = we; wr_addr = wa; datIn = d;
    rd_addr_a = ra; rd_addr_b = rb; flag_wr_en = fwe; flag_in = fin;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random(input bit allow_reset);
    logic r;
    r = allow_reset && ($urandom_range(31) == 0);
    drive(r, 1'($urandom), 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom),
          1'($urandom), 1'($urandom));
    if (!wr_en) datIn = 8'hxx;
  endtask

  initial begin
    drive(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    tick();

    // Random preload, then a one-cycle reset with a random write in flight.
    for (int i = 0; i < 20; i++) begin
      drive_random(1'b0);
      tick();
    end
    drive(1'b1, 1'b1, 3'($urandom), 8'($urandom), 3'd0, 3'd0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 1'b0, 1'b0);
      @(negedge clk);
      check("reset_dat_a", dat_a, 8'h00);
      check("reset_dat_b", dat_b, 8'h00);
      tick();
    end
    check("reset_flag", flag_out, 1'b0);
    check("reset_count", wr_count, 8'd0);

    // Back-to-back writes to r3 and r7.
    drive(1'b0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 3'd7, 8'h3C, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0, 1'b0);
    @(negedge clk);
    check("r3_read", dat_a, 8'hA5);
    check("r7_read", dat_b, 8'h3C);
    check("count_two", wr_count, 8'd2);
    tick();

    // Same-cycle write and read of r2.
    drive(1'b0, 1'b1, 3'd2, 8'h11, 3'd2, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
`ifdef WB_REG_BYPASS_EN
    check("same_cycle_a", dat_a, 8'h11);
`else
    check("same_cycle_a", dat_a, 8'h00);
`endif
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("next_cycle_a", dat_a, 8'h11);
    tick();

    // Reset wins over a simultaneous write to r5.
    drive(1'b1, 1'b1, 3'd5, 8'hFF, 3'd5, 3'd5, 1'b0, 1'b0);
    @(negedge clk);
    check("reset_no_bypass", dat_a, 8'h00);
    tick();
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("r5_after_reset", dat_a, 8'h00);
    check("count_after_reset", wr_count, 8'd0);
    tick();

    // Flag set and clear without register writes.
    drive(1'b0, 1'b1, 3'd1, 8'h77, 3'd1, 3'd1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'd1, 8'h00, 3'd1, 3'd1, 1'b1, 1'b1);
    tick();
    @(negedge clk);
    check("flag_set", flag_out, 1'b1);
    check("regs_unchanged", dat_a, 8'h77);
    drive(1'b0, 1'b0, 3'd1, 8'h00, 3'd1, 3'd1, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    check("flag_clear", flag_out, 1'b0);
    tick();

    // 300 consecutive writes saturate the counter; the last one lands in r6.
    for (int i = 0; i < 300; i++) begin
      if (i == 299) drive(1'b0, 1'b1, 3'd6, 8'h5A, 3'($urandom), 3'($urandom), 1'b0, 1'b0);
      else drive(1'b0, 1'b1, 3'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 1'b0, 1'b0);
    @(negedge clk);
    check("count_saturated", wr_count, 8'd255);
    check("last_write_r6", dat_a, 8'h5A);
    tick();

    // Long random run with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      drive_random(1'b1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Architectural register file at the write-back end of the datapath.
- Its write data port is driven directly by the write-back data selector (select among ALU result, memory load data, immediate and move source).
- Provides two combinational read ports to the decode/execute stage and a single-bit condition flag register written alongside ALU results.
- All state updates occur on the rising clock edge; reads are asynchronous.

Parameters:
- DATA_W, 8, width of each register and of datIn/read data
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of registers (must equal 2**ADDR_W)

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  register write enable for this cycle
- wr_addr  input  ADDR_W  destination register index
- datIn  input  DATA_W  write-back data from the write-back selector
- rd_addr_a  input  ADDR_W  read port A index
- rd_addr_b  input  ADDR_W  read port B index
- dat_a  output  DATA_W  contents of register rd_addr_a
- dat_b  output  DATA_W  contents of register rd_addr_b
- flag_wr_en  input  1  condition flag write enable
- flag_in  input  1  new condition flag value
- flag_out  output  1  current condition flag
- wr_count  output  8  count of committed register writes, saturating

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). Reset acts only on a rising clk edge while reset=1.
- Reset:
  - All NUM_REGS registers clear to 0 and flag clears to 0.
  - wr_count clears to 0.
  - Reset has priority over wr_en and flag_wr_en in the same cycle; the write is dropped.
  - After reset, dat_a = dat_b = 0 and flag_out = 0 for any address.
- Write:
  - On rising edge with reset=0 and wr_en=1, regs[wr_addr] <= datIn.
  - Write latency is 1 cycle: the new value is visible on the read ports from the cycle after the edge.
  - wr_en=0 leaves all registers unchanged regardless of wr_addr/datIn.
- Read:
  - dat_a = regs[rd_addr_a] and dat_b = regs[rd_addr_b], purely combinational.
  - Both ports may address the same register; both return the same value.
- Flag:
  - On rising edge with reset=0 and flag_wr_en=1, flag <= flag_in.
  - The flag is independent of wr_en; both may occur in the same cycle.
- wr_count:
  - Increments by 1 on each edge where reset=0 and wr_en=1.
  - Saturates at 255; it does not wrap.
- Register 0 is an ordinary writable register (no hardwired zero).
- Out-of-range addresses are impossible because NUM_REGS = 2**ADDR_W.
- X on datIn with wr_en=0 must not propagate into state.
- Same-cycle write and read of one address: governed by the optional feature below.

Optional Feature:
- Macro: WB_REG_BYPASS_EN
- Defined:
  - When wr_en=1, reset=0 and rd_addr_a==wr_addr, dat_a = datIn combinationally in the same cycle. Same rule for port B.
  - When reset=1, no bypass: outputs show stored values.
- Not defined:
  - Read ports always show stored contents. A same-cycle read of the address being written returns the old value; the new value appears the next cycle.

Test Plan:
- Assert reset 1 cycle after random preload -> all regs read 0, flag_out=0, wr_count=0.
- Write 8'hA5 to r3, then 8'h3C to r7 on consecutive cycles, read a=3, b=7 -> dat_a=8'hA5, dat_b=8'h3C from the cycle after the second write; wr_count=2.
- Hold wr_en=1, wr_addr=2, datIn=8'h11 with rd_addr_a=2 in the write cycle:
  - Without macro: dat_a=old value (0), then 8'h11 next cycle.
  - With WB_REG_BYPASS_EN: dat_a=8'h11 in the same cycle.
- Assert reset and wr_en=1 (r5, 8'hFF) in the same cycle -> r5 reads 0 afterwards and wr_count=0.
- flag_wr_en=1, flag_in=1 while wr_en=0 -> flag_out=1 next cycle, registers unchanged; then flag_in=0 -> flag_out=0.
- 300 consecutive writes -> wr_count reaches 255 and stays 255; the last datIn is stored at its target address.
